md_issue_ctrl: RTL and testbench
================================

MD_ISSUE_CTRL -- requirements
Module: md_issue_ctrl

Interface
REQ-001 Parameters, one per line (name, default, meaning): MUL_LAT, 5, multiply busy cycles; DIV_LAT, 10, divide busy cycles.
REQ-002 Clk  in  1  single clock; all state on rising edge.
REQ-003 Rst  in  1  asynchronous, active-high reset.
REQ-004 IsMd  in  1  E-stage instruction is MULT/MULTU/DIV/DIVU.
REQ-005 IsMt  in  1  E-stage instruction is MTHI/MTLO.
REQ-006 IsMf  in  1  E-stage instruction is MFHI/MFLO.
REQ-007 OpIn  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-008 HiLoIn  in  1  MT target: 0 Lo, 1 Hi.
REQ-009 Flush  in  1  E-stage instruction cancelled by exception/interrupt.
REQ-010 BusyIn  in  1  busy flag returned by the multiply/divide unit.
REQ-011 Start  out  1  one-cycle issue strobe to the unit.
REQ-012 Op  out  2  operation code to the unit; equals OpIn.
REQ-013 We  out  1  HI/LO write strobe to the unit.
REQ-014 HiLo  out  1  write target to the unit; equals HiLoIn.
REQ-015 Stall  out  1  freeze F/D/E stages this cycle.
REQ-016 Err  out  1  sticky busy-mismatch flag (see Configuration).

Function
REQ-017 States SHALL be IDLE, BUSY_MUL, BUSY_DIV, and ERR (ERR only when checking is compiled in).
REQ-018 Start SHALL equal IsMd & state==IDLE & !Flush; combinational.
REQ-019 We SHALL equal IsMt & state==IDLE & !Flush; combinational.
REQ-020 Stall SHALL equal (IsMd|IsMt|IsMf) & state!=IDLE.
REQ-021 On a Start edge: OpIn[1]=0 -> BUSY_MUL with cnt=MUL_LAT; OpIn[1]=1 -> BUSY_DIV with cnt=DIV_LAT.
REQ-022 In BUSY_x: cnt SHALL decrement each edge; on the edge with cnt==1, go to IDLE. Busy lasts exactly LAT cycles, ending on the edge the unit writes HI/LO.
REQ-023 An MF request in the first IDLE cycle after BUSY_x SHALL not stall and reads the new HI/LO.
REQ-024 Flush during BUSY_x SHALL NOT abort the count; the unit cannot be cancelled.
REQ-025 Flush and IsMd in the same IDLE cycle: no Start, state stays IDLE.
REQ-026 IsMd and IsMt together is illegal input; IsMd takes priority, and We is suppressed.
REQ-027 cnt SHALL be 4 bits and saturate at 0; LAT parameters SHALL be in the range 1..15.

Reset
REQ-028 Rst high SHALL immediately force state=IDLE, cnt=0, Err=0, independent of Clk.
REQ-029 During reset: Start=0, We=0, Stall=0.
REQ-030 Reset mid-operation SHALL abandon the count; the unit is reset by the same Rst.

Configuration
REQ-031 Macro MD_BUSY_CHECK_EN defined: a mismatch SHALL be flagged when BusyIn=0 in BUSY_x with cnt>0, or BusyIn=1 in IDLE not on the cycle right after a Start edge.
REQ-032 On a mismatch: Err=1 sticky, state goes to ERR, and Stall=IsMd|IsMt|IsMf until Rst.
REQ-033 Macro undefined: no ERR state, Err tied 0, BusyIn unused.

Structure
REQ-034 A shared package SHALL hold the Op encodings (MD_MULTU..MD_DIV), the state encodings, and default MUL_LAT/DIV_LAT.
REQ-035 Sub-module md_lat_cnt (load/decrement/zero-detect counter) is natural; everything else is flat.

Verification
REQ-036 MULT issued from IDLE: Start=1 one cycle; an MFLO issued in each of the next 5 cycles sees Stall=1; the cycle after that sees Stall=0.
REQ-037 DIVU followed immediately by MTHI: Stall=1 for 10 cycles, then We=1, HiLo=1, with no Start.
REQ-038 Flush=1 with IsMd=1 in IDLE: Start=0, state IDLE; next cycle IsMf=1 gives Stall=0.
REQ-039 Rst pulsed mid-MULT (cnt=3) between edges: Stall=0 and state IDLE immediately; a new DIV issues next cycle.
REQ-040 With MD_BUSY_CHECK_EN, BusyIn forced 0 on the 2nd BUSY_MUL cycle: Err=1 next edge; any MT/MF/MD stalls until Rst.
REQ-041 Without MD_BUSY_CHECK_EN, same stimulus: Err=0, IDLE after 5 cycles.

Source files
------------

// File: rtl/md_issue_ctrl_pkg.sv
// Shared encodings and defaults for the multiply/divide issue controller.
// The ERR state exists only when MD_BUSY_CHECK_EN is defined.
package md_issue_ctrl_pkg;

   localparam logic [1:0] MD_MULTU = 2'b00;
   localparam logic [1:0] MD_MULT  = 2'b01;
   localparam logic [1:0] MD_DIVU  = 2'b10;
   localparam logic [1:0] MD_DIV   = 2'b11;

   localparam int unsigned MUL_LAT_DEF = 5;
   localparam int unsigned DIV_LAT_DEF = 10;

`ifdef MD_BUSY_CHECK_EN
   typedef enum logic [1:0] {StIdle, StBusyMul, StBusyDiv, StErr} md_state_e;
`else
   typedef enum logic [1:0] {StIdle, StBusyMul, StBusyDiv} md_state_e;
`endif

   // Clamp a latency parameter into the 4-bit counter range 1..15.
   function automatic logic [3:0] lat4(input int unsigned lat);
      if (lat == 0) begin
         return 4'd1;
      end else if (lat > 15) begin
         return 4'd15;
      end else begin
         return 4'(lat);
      end
   endfunction

endpackage

// File: rtl/md_lat_cnt.sv
// Busy-latency counter: load, decrement saturating at zero, last-cycle detect.
module md_lat_cnt (
   input  logic       Clk,
   input  logic       Rst,
   input  logic       load,
   input  logic [3:0] lat,
   input  logic       dec,
   output logic [3:0] cnt,
   output logic       last
);

   logic [3:0] cnt_q;

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         cnt_q <= 4'd0;
      end else if (load) begin
         cnt_q <= lat;
      end else if (dec && cnt_q != 4'd0) begin
         cnt_q <= cnt_q - 4'd1;
      end
   end

   assign cnt  = cnt_q;
   assign last = (cnt_q == 4'd1);

endmodule

// File: rtl/md_issue_ctrl.sv
// Issue/stall control for the E-stage multiply/divide unit.
// Optional busy cross-check against the unit enabled by MD_BUSY_CHECK_EN.
module md_issue_ctrl
   import md_issue_ctrl_pkg::*;
#(
   parameter int unsigned MUL_LAT = MUL_LAT_DEF,
   parameter int unsigned DIV_LAT = DIV_LAT_DEF
) (
   input  logic       Clk,
   input  logic       Rst,
   input  logic       IsMd,
   input  logic       IsMt,
   input  logic       IsMf,
   input  logic [1:0] OpIn,
   input  logic       HiLoIn,
   input  logic       Flush,
   input  logic       BusyIn,
   output logic       Start,
   output logic [1:0] Op,
   output logic       We,
   output logic       HiLo,
   output logic       Stall,
   output logic       Err
);

   localparam logic [3:0] MulLat4 = lat4(MUL_LAT);
   localparam logic [3:0] DivLat4 = lat4(DIV_LAT);

   md_state_e  state_q, state_d;
   logic       idle, busy;
   logic [3:0] cnt;
   logic       cnt_last;

   assign idle = (state_q == StIdle);
   assign busy = (state_q == StBusyMul) || (state_q == StBusyDiv);

   // Rst gating keeps strobes quiet even while the inputs are still active.
   assign Start = IsMd & idle & ~Flush & ~Rst;
   assign We    = IsMt & ~IsMd & idle & ~Flush & ~Rst;
   assign Stall = (IsMd | IsMt | IsMf) & ~idle & ~Rst;
   assign Op    = OpIn;
   assign HiLo  = HiLoIn;

   md_lat_cnt u_lat_cnt (
      .Clk  (Clk),
      .Rst  (Rst),
      .load (Start),
      .lat  (OpIn[1] ? DivLat4 : MulLat4),
      .dec  (busy),
      .cnt  (cnt),
      .last (cnt_last)
   );

`ifdef MD_BUSY_CHECK_EN
   logic start_q, err_q, mismatch;

   // The unit may still report busy on the cycle right after an issue edge.
   assign mismatch = (busy & ~BusyIn & (cnt != 4'd0)) | (idle & BusyIn & ~start_q);
   assign Err      = err_q;
`else
   logic unused_chk;

   assign unused_chk = ^{BusyIn, cnt};
   assign Err        = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (Start) begin
               state_d = OpIn[1] ? StBusyDiv : StBusyMul;
            end
         end
         StBusyMul, StBusyDiv: begin
            if (cnt_last) begin
               state_d = StIdle;
            end
         end
         default: state_d = state_q;
      endcase
`ifdef MD_BUSY_CHECK_EN
      if (mismatch) begin
         state_d = StErr;
      end
`endif
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q <= StIdle;
`ifdef MD_BUSY_CHECK_EN
         start_q <= 1'b0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
`ifdef MD_BUSY_CHECK_EN
         start_q <= Start;
         if (mismatch) begin
            err_q <= 1'b1;
         end
`endif
      end
   end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed bench for md_issue_ctrl: behavioural issue model feeds a scoreboard queue.
// Covers both builds of MD_BUSY_CHECK_EN.
module tb_md_issue_ctrl;
   import md_issue_ctrl_pkg::*;

   localparam int unsigned MulLat = 5;
   localparam int unsigned DivLat = 10;
`ifdef MD_BUSY_CHECK_EN
   localparam bit ChkEn = 1'b1;
`else
   localparam bit ChkEn = 1'b0;
`endif

   logic       Clk = 1'b0;
   logic       Rst;
   logic       IsMd, IsMt, IsMf, HiLoIn, Flush, BusyIn;
   logic [1:0] OpIn;
   logic       Start, We, HiLo, Stall, Err;
   logic [1:0] Op;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic       start;
      logic       we;
      logic       stall;
      logic       err;
      logic [1:0] op;
      logic       hilo;
   } exp_t;

   exp_t exp_q[$];

   // Reference model: remaining unit busy cycles, sticky error, last-edge issue.
   int mcnt = 0;
   bit merr = 1'b0;
   bit mstart_prev = 1'b0;

   md_issue_ctrl #(
      .MUL_LAT (MulLat),
      .DIV_LAT (DivLat)
   ) dut (
      .Clk    (Clk),
      .Rst    (Rst),
      .IsMd   (IsMd),
      .IsMt   (IsMt),
      .IsMf   (IsMf),
      .OpIn   (OpIn),
      .HiLoIn (HiLoIn),
      .Flush  (Flush),
      .BusyIn (BusyIn),
      .Start  (Start),
      .Op     (Op),
      .We     (We),
      .HiLo   (HiLo),
      .Stall  (Stall),
      .Err    (Err)
   );

   always #5 Clk = ~Clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h required %0h", tag, got, exp);
      end
   endtask

   // One cycle: drive at negedge, check 1ns later, then advance the model past the edge.
   task automatic step(input bit md, input bit mt, input bit mf, input logic [1:0] op,
                       input bit hl, input bit fl, input bit bz0, input string tag);
      exp_t e;
      bit   idle, st;
      @(negedge Clk);
      IsMd   = md;
      IsMt   = mt;
      IsMf   = mf;
      OpIn   = op;
      HiLoIn = hl;
      Flush  = fl;
      BusyIn = (mcnt > 0) && !bz0;
      idle   = (mcnt == 0) && !merr;
      st     = md && idle && !fl;
      e.start = st;
      e.we    = mt && !md && idle && !fl;
      e.stall = (md || mt || mf) && !idle;
      e.err   = merr;
      e.op    = op;
      e.hilo  = hl;
      exp_q.push_back(e);
      #1;
      e = exp_q.pop_front();
      chk({tag, ".start"}, {3'b0, Start}, {3'b0, e.start});
      chk({tag, ".we"},    {3'b0, We},    {3'b0, e.we});
      chk({tag, ".stall"}, {3'b0, Stall}, {3'b0, e.stall});
      chk({tag, ".err"},   {3'b0, Err},   {3'b0, e.err});
      chk({tag, ".op"},    {2'b0, Op},    {2'b0, e.op});
      chk({tag, ".hilo"},  {3'b0, HiLo},  {3'b0, e.hilo});
      if (ChkEn && !merr &&
          (((mcnt > 0) && !BusyIn) || (idle && BusyIn && !mstart_prev))) begin
         merr = 1'b1;
      end
      mstart_prev = st;
      if (st) begin
         mcnt = op[1] ? int'(DivLat) : int'(MulLat);
      end else if (mcnt > 0) begin
         mcnt--;
      end
   endtask

   // Reset asserted and released between two edges.
   task automatic reset_pulse(input bit md, input bit mf, input logic [1:0] op);
      @(negedge Clk);
      IsMd = md;
      IsMt = 1'b1;
      IsMf = mf;
      OpIn = op;
      Flush = 1'b0;
      BusyIn = 1'b0;
      Rst = 1'b1;
      mcnt = 0;
      merr = 1'b0;
      mstart_prev = 1'b0;
      #1;
      chk("rst.start", {3'b0, Start}, 4'd0);
      chk("rst.we",    {3'b0, We},    4'd0);
      chk("rst.stall", {3'b0, Stall}, 4'd0);
      chk("rst.err",   {3'b0, Err},   4'd0);
      Rst  = 1'b0;
      IsMt = 1'b0;
      #1;
      chk("rst_rel.stall", {3'b0, Stall}, 4'd0);
      chk("rst_rel.err",   {3'b0, Err},   4'd0);
      IsMd = 1'b0;
      IsMf = 1'b0;
   endtask

   initial begin
      Rst = 1'b1;
      {IsMd, IsMt, IsMf, HiLoIn, Flush, BusyIn} = '0;
      OpIn = MD_MULTU;

      reset_pulse(1'b1, 1'b1, MD_DIV);

      // MULT then MFLO in each busy cycle and the first idle cycle
      step(1, 0, 0, MD_MULT, 0, 0, 0, "mult_issue");
      repeat (5) step(0, 0, 1, MD_MULTU, 0, 0, 0, "mult_mf_busy");
      step(0, 0, 1, MD_MULTU, 0, 0, 0, "mult_mf_free");

      // DIVU then MTHI: ten stalled cycles, then the HI write
      step(1, 0, 0, MD_DIVU, 0, 0, 0, "divu_issue");
      repeat (11) step(0, 1, 0, MD_MULTU, 1, 0, 0, "divu_mthi");

      // Flush cancels an issue in IDLE
      step(1, 0, 0, MD_DIV, 0, 1, 0, "flush_issue");
      step(0, 0, 1, MD_MULTU, 0, 0, 0, "flush_mf");

      // MD and MT together: MD wins, no write
      step(1, 1, 0, MD_MULTU, 1, 0, 0, "md_mt_both");
      repeat (5) step(0, 0, 0, MD_MULTU, 0, 0, 0, "drain");
      step(0, 1, 0, MD_MULTU, 0, 0, 0, "mtlo_idle");

      // Flush while busy does not shorten the count
      step(1, 0, 0, MD_DIV, 0, 0, 0, "div_issue");
      repeat (10) step(0, 0, 1, MD_MULTU, 0, 1, 0, "div_flush_busy");
      step(0, 0, 1, MD_MULTU, 0, 0, 0, "div_done");

      // Reset with cnt=3 mid-MULT, then a DIV issues right away
      step(1, 0, 0, MD_MULT, 0, 0, 0, "mult2_issue");
      repeat (2) step(0, 0, 1, MD_MULTU, 0, 0, 0, "mult2_busy");
      reset_pulse(1'b1, 1'b1, MD_DIV);
      step(1, 0, 0, MD_DIV, 0, 0, 0, "div_after_rst");
      repeat (10) step(0, 0, 1, MD_MULTU, 0, 0, 0, "div2_busy");
      step(0, 0, 1, MD_MULTU, 0, 0, 0, "div2_done");

      // Unit drops busy on the 2nd BUSY_MUL cycle
      step(1, 0, 0, MD_MULT, 0, 0, 0, "chk_issue");
      step(0, 0, 1, MD_MULTU, 0, 0, 0, "chk_busy1");
      step(0, 0, 1, MD_MULTU, 0, 0, 1, "chk_busy2_drop");
      repeat (6) step(0, 0, 1, MD_MULTU, 0, 0, 0, "chk_after");
      step(0, 1, 0, MD_MULTU, 1, 0, 0, "chk_mt");
      step(1, 0, 0, MD_MULTU, 0, 0, 0, "chk_md");
      step(0, 0, 1, MD_MULTU, 0, 0, 0, "chk_mf");
      chk("err_build", {3'b0, Err}, {3'b0, ChkEn});
      reset_pulse(1'b0, 1'b1, MD_MULTU);
      step(0, 0, 1, MD_MULTU, 0, 0, 0, "post_rst_mf");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
